mlab_delay_bist: RTL and testbench

Synthesizable stimulus-and-check companion for `mlab_delay`, used for on-chip self-test of the MLAB delay line. It drives a counting pattern into the delay line's `din` with pseudo-random `ena` gating. It waits for the line's parity warm-up to clear, then checks every cycle that `din - dout` equals `LATENCY`. At the end it reports pass/fail, an error count and the first bad delta. It sits beside one `mlab_delay` instance and connects port-for-port to its `din`, `ena`, `dout` and `parity_error`.

---
 rtl/mlab_delay_bist.sv | 108 ++++++++++
 tb/tb_mlab_delay_bist.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mlab_delay_bist.sv
// mlab_delay_bist: drives a counting pattern into an mlab_delay line and checks
// that din - dout stays equal to LATENCY once parity warm-up has cleared.
module mlab_delay_bist #(
   parameter int WORDS         = 46,
   parameter int BITS_PER_WORD = 9,
   parameter int LATENCY       = 10,
   parameter int CHECK_CYCLES  = 10000,
   parameter int WARMUP_MAX    = 1024,
   parameter bit ENA_RANDOM    = 1'b1
) (
   input  logic                             clk,
   input  logic                             sclr,
   input  logic                             start,
   output logic [WORDS*BITS_PER_WORD-1:0]   din,
   output logic                             ena,
   input  logic [WORDS*BITS_PER_WORD-1:0]   dout,
   input  logic                             parity_error,
   output logic                             busy,
   output logic                             done,
   output logic                             pass,
   output logic                             timeout,
   output logic [15:0]                      err_count,
   output logic [WORDS*BITS_PER_WORD-1:0]   first_delta
);
   localparam int W   = WORDS*BITS_PER_WORD;
   localparam int WCW = $clog2(WARMUP_MAX+1);
   localparam int ECW = $clog2(LATENCY+2);
   localparam int CCW = $clog2(CHECK_CYCLES+1);

   typedef enum logic [1:0] {IDLE, WARMUP, CHECK, DONE} state_t;
   state_t state, state_nx;

   logic [15:0]    lfsr;
   logic [WCW-1:0] wu_clk;
   logic [ECW-1:0] wu_ena;
   logic [CCW-1:0] chk_cnt;
   logic [W-1:0]   delta_q;
   logic           pe_q;
   logic           run, launch, warm_ok, warm_to, chk_last, err;

   always_comb begin
      run      = state == WARMUP || state == CHECK;
      launch   = start && !run;
      warm_ok  = !parity_error && wu_ena >= ECW'(LATENCY+1);
      warm_to  = wu_clk == WCW'(WARMUP_MAX-1);
      chk_last = chk_cnt == CCW'(CHECK_CYCLES-1);
      err      = pe_q || delta_q != W'(LATENCY);
      ena      = run && (!ENA_RANDOM || lfsr[0]);
      busy     = run;
      done     = state == DONE;
      state_nx = launch ? WARMUP
               : state == WARMUP ? (warm_ok ? CHECK : warm_to ? DONE : WARMUP)
               : (state == CHECK && chk_last) ? DONE : state;
   end

   always_ff @(posedge clk) begin
      if (sclr) begin
         state       <= IDLE;
         din         <= '0;
         lfsr        <= 16'hACE1;
         wu_clk      <= '0;
         wu_ena      <= '0;
         chk_cnt     <= '0;
         delta_q     <= '0;
         pe_q        <= 1'b0;
         err_count   <= '0;
         first_delta <= '0;
         timeout     <= 1'b0;
         pass        <= 1'b0;
      end else begin
         state   <= state_nx;
         delta_q <= din - dout;
         pe_q    <= parity_error;
         if (run)
            lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
         if (launch) begin
            din         <= '0;
            wu_clk      <= '0;
            wu_ena      <= '0;
            chk_cnt     <= '0;
            err_count   <= '0;
            first_delta <= '0;
            timeout     <= 1'b0;
            pass        <= 1'b0;
         end else begin
            if (ena)
               din <= din + W'(1);
            if (state == WARMUP) begin
               wu_clk <= wu_clk + WCW'(1);
               if (ena && wu_ena != ECW'(LATENCY+1))
                  wu_ena <= wu_ena + ECW'(1);
               if (!warm_ok && warm_to)
                  timeout <= 1'b1;
            end
            // the final compare still counts toward pass, hence !err alongside err_count
            if (state == CHECK) begin
               chk_cnt <= chk_cnt + CCW'(1);
               if (err && err_count != 16'hFFFF)
                  err_count <= err_count + 16'd1;
               if (err && err_count == 16'd0)
                  first_delta <= delta_q;
               if (chk_last)
                  pass <= err_count == 16'd0 && !err;
            end
         end
      end
   end
endmodule

// File: tb/tb_mlab_delay_bist.sv
// tb_mlab_delay_bist: scoreboard bench with behavioural delay-line models for
// a wide random-ena instance and a narrow always-enabled instance.
module tb_mlab_delay_bist;
   localparam int W0 = 46*9;
   localparam int W1 = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic sclr = 1'b1, start0 = 1'b0, start1 = 1'b0;
   logic [W0-1:0] din0, dout0, fd0;
   logic [W1-1:0] din1, dout1, fd1;
   logic ena0, pe0, busy0, done0, pass0, to0;
   logic ena1, pe1, busy1, done1, pass1, to1;
   logic [15:0] ec0, ec1;

   mlab_delay_bist #(.WORDS(46), .BITS_PER_WORD(9), .LATENCY(10), .CHECK_CYCLES(1000),
                     .WARMUP_MAX(1024), .ENA_RANDOM(1'b1)) dut0 (
      .clk(clk), .sclr(sclr), .start(start0), .din(din0), .ena(ena0), .dout(dout0),
      .parity_error(pe0), .busy(busy0), .done(done0), .pass(pass0), .timeout(to0),
      .err_count(ec0), .first_delta(fd0));

   mlab_delay_bist #(.WORDS(1), .BITS_PER_WORD(4), .LATENCY(10), .CHECK_CYCLES(100),
                     .WARMUP_MAX(1024), .ENA_RANDOM(1'b0)) dut1 (
      .clk(clk), .sclr(sclr), .start(start1), .din(din1), .ena(ena1), .dout(dout1),
      .parity_error(pe1), .busy(busy1), .done(done1), .pass(pass1), .timeout(to1),
      .err_count(ec1), .first_delta(fd1));

   // Delay-line models: ena-gated shift, parity high for the first 12 enabled cycles
   logic [W0-1:0] sr0 [16];
   logic [W1-1:0] sr1 [10];
   int ml = 10, pc0 = 0, pc1 = 0;
   logic stuck = 1'b0, flip = 1'b0;

   always @(posedge clk) begin
      if (sclr) begin
         pc0 <= 0;
         pc1 <= 0;
         for (int i = 0; i < 16; i++) sr0[i] <= '0;
         for (int i = 0; i < 10; i++) sr1[i] <= '0;
      end else begin
         if (start0 && !busy0) pc0 <= 0;
         else if (ena0 && pc0 < 100) pc0 <= pc0 + 1;
         if (start1 && !busy1) pc1 <= 0;
         else if (ena1 && pc1 < 100) pc1 <= pc1 + 1;
         if (ena0) begin
            sr0[0] <= din0;
            for (int i = 1; i < 16; i++) sr0[i] <= sr0[i-1];
         end
         if (ena1) begin
            sr1[0] <= din1;
            for (int i = 1; i < 10; i++) sr1[i] <= sr1[i-1];
         end
      end
   end

   assign dout0 = sr0[ml-1] ^ W0'(flip);
   assign pe0   = stuck || pc0 < 12;
   assign dout1 = sr1[9];
   assign pe1   = pc1 < 12;

   int checks = 0, errors = 0;

   typedef struct {
      string         name;
      logic          pass, to;
      logic [15:0]   ec;
      logic [W0-1:0] fd, fd_alt, din;
      logic          din_chk;
      int            bmin, bmax;
   } exp_t;
   exp_t q0[$], q1[$];

   function automatic exp_t mk(string n, logic p, logic t, logic [15:0] ec, logic [W0-1:0] fd,
                               logic [W0-1:0] fa, logic [W0-1:0] d, logic dc, int bmin, int bmax);
      exp_t e;
      e.name = n; e.pass = p; e.to = t; e.ec = ec; e.fd = fd; e.fd_alt = fa;
      e.din = d; e.din_chk = dc; e.bmin = bmin; e.bmax = bmax;
      return e;
   endfunction

   task automatic check(string n, logic [W0-1:0] act, logic [W0-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h", n, act, exp);
      end
   endtask

   task automatic score(exp_t e, logic p, logic t, logic [15:0] ec, logic [W0-1:0] fd,
                        logic [W0-1:0] d, int bc);
      check({e.name, ".pass"}, W0'(p), W0'(e.pass));
      check({e.name, ".timeout"}, W0'(t), W0'(e.to));
      check({e.name, ".err_count"}, W0'(ec), W0'(e.ec));
      checks++;
      if (fd !== e.fd && fd !== e.fd_alt) begin
         errors++;
         $display("FAIL %s.first_delta: got %0h, want %0h or %0h", e.name, fd, e.fd, e.fd_alt);
      end
      checks++;
      if (bc < e.bmin || bc > e.bmax) begin
         errors++;
         $display("FAIL %s.busy_cycles: got %0d, want %0d..%0d", e.name, bc, e.bmin, e.bmax);
      end
      if (e.din_chk) check({e.name, ".din"}, d, e.din);
   endtask

   // Monitors: pop one expectation per rising edge of done
   int bc0 = 0, bc1 = 0;
   logic bd0 = 1'b0, dd0 = 1'b0, bd1 = 1'b0, dd1 = 1'b0;

   always @(negedge clk) begin
      bc0 = busy0 ? (bd0 ? bc0 + 1 : 1) : bc0;
      if (done0 && !dd0) begin
         if (q0.size() == 0) begin
            checks++; errors++;
            $display("FAIL dut0.unexpected_done: got done=1, want no done");
         end else score(q0.pop_front(), pass0, to0, ec0, fd0, din0, bc0);
      end
      bd0 = busy0; dd0 = done0;
   end

   always @(negedge clk) begin
      bc1 = busy1 ? (bd1 ? bc1 + 1 : 1) : bc1;
      if (done1 && !dd1) begin
         if (q1.size() == 0) begin
            checks++; errors++;
            $display("FAIL dut1.unexpected_done: got done=1, want no done");
         end else score(q1.pop_front(), pass1, to1, ec1, W0'(fd1), W0'(din1), bc1);
      end
      bd1 = busy1; dd1 = done1;
   end

   task automatic tick(int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic go0;
      start0 = 1'b1; tick(1); start0 = 1'b0;
   endtask

   task automatic go1;
      start1 = 1'b1; tick(1); start1 = 1'b0;
   endtask

   task automatic wait_done0(string n);
      int i = 0;
      while (!done0 && i < 3000) begin tick(1); i++; end
      check({n, ".done_seen"}, W0'(done0), W0'(1));
   endtask

   task automatic wait_done1(string n);
      int i = 0;
      while (!done1 && i < 3000) begin tick(1); i++; end
      check({n, ".done_seen"}, W0'(done1), W0'(1));
   endtask

   task automatic rst_checks(string n);
      check({n, ".din"}, din0, '0);
      check({n, ".ena"}, W0'(ena0), '0);
      check({n, ".busy"}, W0'(busy0), '0);
      check({n, ".done"}, W0'(done0), '0);
      check({n, ".pass"}, W0'(pass0), '0);
      check({n, ".timeout"}, W0'(to0), '0);
      check({n, ".err_count"}, W0'(ec0), '0);
      check({n, ".first_delta"}, fd0, '0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      sclr = 1'b1;
      tick(3);
      rst_checks("reset");
      check("reset.dut1_busy", W0'(busy1), '0);
      sclr = 1'b0;
      tick(2);
      // warm-up needs ~24 clocks with random ena, so 200 is ample headroom
      q0.push_back(mk("A", 1'b1, 1'b0, 16'd0, '0, '0, '0, 1'b0, 1000, 1200));
      go0;
      wait_done0("A");
      tick(5);
      check("A.ena_in_done", W0'(ena0), '0);
      check("A.done_held", W0'(done0), W0'(1));
      q0.push_back(mk("B", 1'b0, 1'b0, 16'd1, W0'(11), W0'(9), '0, 1'b0, 1000, 1200));
      go0;
      tick(499);
      flip = 1'b1;
      tick(1);
      flip = 1'b0;
      wait_done0("B");
      ml = 11;
      q0.push_back(mk("C", 1'b0, 1'b0, 16'd1000, W0'(11), W0'(11), '0, 1'b0, 1000, 1200));
      go0;
      tick(599);
      start0 = 1'b1;
      tick(1);
      start0 = 1'b0;
      wait_done0("C");
      ml = 10;
      stuck = 1'b1;
      q0.push_back(mk("D", 1'b0, 1'b1, 16'd0, '0, '0, '0, 1'b0, 1024, 1024));
      go0;
      wait_done0("D");
      stuck = 1'b0;
      ml = 11;
      go0;
      tick(399);
      check("E.errors_before_sclr", W0'(ec0 != 16'd0), W0'(1));
      sclr = 1'b1;
      tick(1);
      rst_checks("E_sclr");
      sclr = 1'b0;
      ml = 10;
      tick(2);
      q0.push_back(mk("F", 1'b1, 1'b0, 16'd0, '0, '0, '0, 1'b0, 1000, 1200));
      go0;
      wait_done0("F");
      // 13 warm-up clocks + 100 compares, ena high throughout: din ends at 113 mod 16
      q1.push_back(mk("G", 1'b1, 1'b0, 16'd0, '0, '0, W0'(1), 1'b1, 113, 113));
      go1;
      wait_done1("G");
      tick(5);
      check("G.ena_in_done", W0'(ena1), '0);
      check("G.din_held", W0'(din1), W0'(1));
      q1.push_back(mk("H", 1'b1, 1'b0, 16'd0, '0, '0, W0'(1), 1'b1, 113, 113));
      go1;
      tick(49);
      start1 = 1'b1;
      tick(1);
      start1 = 1'b0;
      wait_done1("H");
      tick(3);
      check("q0_drained", W0'(q0.size()), '0);
      check("q1_drained", W0'(q1.size()), '0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
